// File: rtl/wb_data_ram_pkg.sv
// Shared constants for the Wishbone data RAM: default address map, firmware
// signature codes and the two-state bus handshake encoding.
package wb_data_ram_pkg;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h3000_0000;
  localparam logic [31:0] DEF_SIG_OFFSET = 32'h0001_0000;

  localparam logic [15:0] SIG_START = 16'hAB60;
  localparam logic [15:0] SIG_PASS  = 16'hAB61;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

endpackage

// File: rtl/wb_data_ram_mem.sv
// Single-port word RAM with byte enables, write-first, one-cycle registered read.
// Latency 1 cycle from i_en to o_rdata; no backpressure, accepts every enabled cycle.
module wb_data_ram_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  i_en,
  input  logic [3:0]            i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;
  logic [31:0] w_merged;

  // Write-first: the read port sees the bytes being written on the same edge.
  always_comb begin
    w_merged = r_mem[i_addr];
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        w_merged[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_en) begin
      r_mem[i_addr] <= w_merged;
      r_rdata       <= w_merged;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone-B4 classic slave: byte-writable firmware RAM plus a 16-bit signature register on io[31:16].
// Latency 1 cycle request-to-ack; no wait states, a request held through ACK is not re-accepted.
module wb_data_ram
  import wb_data_ram_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [31:0] SIG_OFFSET = DEF_SIG_OFFSET
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] sig_o,
  output logic [15:0] sig_oeb
);

  // 33-bit window bounds so a RAM that ends at 4 GiB cannot wrap back to 0.
  localparam logic [32:0] RAM_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0] RAM_HI   = RAM_LO + (33'd4 << ADDR_WIDTH);
  localparam logic [31:0] SIG_ADDR = BASE_ADDR + SIG_OFFSET;

  state_e      r_state;
  logic        r_rd;
  logic        r_ram_hit;
  logic        r_sig_hit;
  logic [15:0] r_sig;
  logic [15:0] r_sig_oeb;

  logic        w_req;
  logic        w_ram_hit;
  logic        w_sig_hit;
  logic        w_mem_en;
  logic [3:0]  w_mem_be;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_dat;

  assign w_req     = wbs_cyc_i & wbs_stb_i & (r_state == IDLE);
  assign w_ram_hit = ({1'b0, wbs_adr_i} >= RAM_LO) && ({1'b0, wbs_adr_i} < RAM_HI);
  assign w_sig_hit = (wbs_adr_i[31:2] == SIG_ADDR[31:2]) && !w_ram_hit;
  assign w_mem_en  = w_req & w_ram_hit;
  assign w_mem_be  = (w_mem_en & wbs_we_i) ? wbs_sel_i : 4'b0000;

  wb_data_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock   (clock),
    .i_en    (w_mem_en),
    .i_be    (w_mem_be),
    .i_addr  (wbs_adr_i[ADDR_WIDTH+1:2]),
    .i_wdata (wbs_dat_i),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state   <= IDLE;
      r_rd      <= 1'b0;
      r_ram_hit <= 1'b0;
      r_sig_hit <= 1'b0;
    end else if (r_state == ACK) begin
      r_state <= IDLE;
    end else if (w_req) begin
      r_state   <= ACK;
      r_rd      <= ~wbs_we_i;
      r_ram_hit <= w_ram_hit;
      r_sig_hit <= w_sig_hit;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sig     <= 16'h0000;
      r_sig_oeb <= 16'hFFFF;
    end else if (w_req && w_sig_hit && wbs_we_i) begin
      if (wbs_sel_i[0]) r_sig[7:0]  <= wbs_dat_i[7:0];
      if (wbs_sel_i[1]) r_sig[15:8] <= wbs_dat_i[15:8];
      if (|wbs_sel_i[1:0]) r_sig_oeb <= 16'h0000;
    end
  end

  // Read data is only driven during ACK; misses and writes return zero.
  always_comb begin
    w_dat = 32'h0;
    if (r_state == ACK && r_rd) begin
      if (r_ram_hit)      w_dat = w_mem_rdata;
      else if (r_sig_hit) w_dat = {16'h0, r_sig};
    end
  end

  assign wbs_ack_o = (r_state == ACK);
  assign wbs_dat_o = w_dat;
  assign sig_o     = r_sig;
  assign sig_oeb   = r_sig_oeb;

endmodule

// File: tb/tb_wb_data_ram.sv
// Randomized scoreboard bench for wb_data_ram against an address-map reference model.
module tb_wb_data_ram;
  import wb_data_ram_pkg::*;

  localparam int          WORDS = 1024;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] SIG_A = 32'h3001_0000;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] sig_o;
  logic [15:0] sig_oeb;

  wb_data_ram dut (
    .clock     (clock),
    .resetb    (resetb),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .sig_o     (sig_o),
    .sig_oeb   (sig_oeb)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          chk_dat;
    logic [31:0] dat;
    logic [15:0] sig;
    logic [15:0] oeb;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [WORDS];
  bit          m_vld [WORDS];
  logic [15:0] m_sig = 16'h0;
  logic [15:0] m_oeb = 16'hFFFF;
  int          nvec = 0;
  int          errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: decode by plain byte-address arithmetic, update, and queue the expected response.
  task automatic model(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, output exp_t e);
    longint a;
    int     idx;
    a = longint'(adr);
    e.chk_dat = 1'b0;
    e.dat     = 32'h0;
    if (a >= longint'(BASE) && a < longint'(BASE) + 4 * WORDS) begin
      idx = int'((a - longint'(BASE)) / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) m_mem[idx][8*b +: 8] = dat[8*b +: 8];
        if (sel == 4'hF) m_vld[idx] = 1'b1;
      end else begin
        e.chk_dat = m_vld[idx];
        e.dat     = m_mem[idx];
      end
    end else if ((adr >> 2) == (SIG_A >> 2)) begin
      if (we) begin
        if (sel[0]) m_sig[7:0]  = dat[7:0];
        if (sel[1]) m_sig[15:8] = dat[15:8];
        if (sel[0] || sel[1]) m_oeb = 16'h0;
      end else begin
        e.chk_dat = 1'b1;
        e.dat     = {16'h0, m_sig};
      end
    end else if (!we) begin
      e.chk_dat = 1'b1;
    end
    e.sig = m_sig;
    e.oeb = m_oeb;
  endtask

  // One bus transfer, started on a falling edge; ack must arrive on the next cycle and last one cycle.
  task automatic xfer(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    exp_t e;
    int   n;
    model(we, sel, adr, dat, e);
    q.push_back(e);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!wbs_ack_o && n < 8);
    chk("ack_latency", 32'(n), 32'd1);
    if (!wbs_ack_o && q.size() > 0) void'(q.pop_front());
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clock);
    chk("ack_one_cycle", {31'h0, wbs_ack_o}, 32'h0);
  endtask

  always @(negedge clock) begin
    if (wbs_ack_o) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_dat) chk("rdata", wbs_dat_o, e.dat);
        chk("sig_o", {16'h0, sig_o}, {16'h0, e.sig});
        chk("sig_oeb", {16'h0, sig_oeb}, {16'h0, e.oeb});
      end
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ack"}, {31'h0, wbs_ack_o}, 32'h0);
    chk({nm, "_dat"}, wbs_dat_o, 32'h0);
    chk({nm, "_sig"}, {16'h0, sig_o}, 32'h0);
    chk({nm, "_oeb"}, {16'h0, sig_oeb}, 32'h0000_FFFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr, dat;
    for (int i = 0; i < WORDS; i++) m_vld[i] = 1'b0;

    repeat (3) @(negedge clock);
    chk_reset_outputs("por");
    resetb = 1'b1;
    @(negedge clock);

    // Basic write/read and byte lanes
    xfer(1'b1, 4'hF, BASE, 32'hDEAD_BEEF);
    xfer(1'b0, 4'hF, BASE, 32'h0);
    xfer(1'b1, 4'h2, BASE, 32'h0000_AB00);
    xfer(1'b0, 4'hF, BASE, 32'h0);
    xfer(1'b1, 4'h0, BASE, 32'hFFFF_FFFF);
    xfer(1'b0, 4'hF, BASE, 32'h0);

    // Reset mid-run after the signature has been driven
    xfer(1'b1, 4'h3, SIG_A, {16'h0, SIG_START});
    resetb = 1'b0;
    m_sig = 16'h0; m_oeb = 16'hFFFF;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clock);
    resetb = 1'b1;
    repeat (10) @(negedge clock);
    chk_reset_outputs("post_reset_idle");
    xfer(1'b0, 4'hF, BASE, 32'h0);

    // Window boundaries
    xfer(1'b1, 4'hF, BASE + 32'd4 * (WORDS - 1), 32'h1234_5678);
    xfer(1'b0, 4'hF, BASE + 32'd4 * (WORDS - 1), 32'h0);
    xfer(1'b1, 4'hF, BASE + 32'd4 * WORDS, 32'h5555_AAAA);
    xfer(1'b0, 4'hF, BASE + 32'd4 * WORDS, 32'h0);
    xfer(1'b0, 4'hF, BASE, 32'h0);
    xfer(1'b0, 4'hF, BASE - 32'd4, 32'h0);

    // Full sweep
    for (int i = 0; i < WORDS; i++) xfer(1'b1, 4'hF, BASE + 32'(4 * i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < WORDS; i++) xfer(1'b0, 4'hF, BASE + 32'(4 * i), 32'h0);

    // Randomized mix over RAM, signature, and miss regions
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: adr = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
        6:       adr = SIG_A + 32'($urandom_range(0, 3));
        7:       adr = BASE + 32'd4 * WORDS + 32'($urandom_range(0, 63));
        8:       adr = BASE - 32'($urandom_range(1, 64));
        default: adr = $urandom;
      endcase
      dat = $urandom;
      xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), adr, dat);
    end

    // Firmware signature sequence
    xfer(1'b1, 4'h3, SIG_A, {16'h0, SIG_START});
    xfer(1'b1, 4'h3, SIG_A, {16'h0, SIG_PASS});
    xfer(1'b0, 4'hF, SIG_A, 32'h0);

    // Reset while a write is being acknowledged: the clocked write survives
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'd28; wbs_dat_i = 32'hCAFE_F00D;
    m_mem[7] = 32'hCAFE_F00D; m_vld[7] = 1'b1;
    @(posedge clock);
    #1;
    chk("ack_before_reset", {31'h0, wbs_ack_o}, 32'h1);
    resetb = 1'b0;
    m_sig = 16'h0; m_oeb = 16'hFFFF;
    #1;
    chk("ack_cleared_by_reset", {31'h0, wbs_ack_o}, 32'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
    xfer(1'b0, 4'hF, BASE + 32'd28, 32'h0);

    repeat (3) @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
